// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder4bit.sv
// 4-bit ripple carry adder exposing every per-bit carry; instantiated beside the sequencer.
module ripple_carry_adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic [3:0] c
);

    always_comb begin : ripple
        logic w_cc;
        sum  = '0;
        c    = '0;
        w_cc = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ w_cc;
            c[i]   = (a[i] & b[i]) | (w_cc & (a[i] ^ b[i]));
            w_cc   = c[i];
        end
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a WIDTH-bit add through an external 4-bit adder, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on both sides.
//
// state   | meaning
// IDLE    | in_ready high, waiting for operands
// RUN     | feeding one nibble per cycle to the adder
// DONE    | result presented with out_valid, waiting for out_ready
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic [3:0]       add_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             w_run;
    logic             w_unused_c;

    assign w_run      = (r_state == ST_RUN);
    assign w_unused_c = ^add_c[1:0];

    // Adder inputs come only from registers so the adder path stays within one cycle.
    assign add_a   = w_run ? r_a[3:0] : 4'd0;
    assign add_b   = w_run ? r_b[3:0] : 4'd0;
    assign add_cin = w_run ? r_carry  : 1'b0;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_carry <= op_cin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a      <= r_a >> NIB_W;
                    r_b      <= r_b >> NIB_W;
                    r_result <= {add_sum, r_result[WIDTH-1:NIB_W]};
                    r_carry  <= add_c[3];
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_cout  <= add_c[3];
                        r_ovf   <= add_c[3] ^ add_c[2];
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench: sequencer plus real 4-bit ripple adder, WIDTH=16.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic [3:0]  add_c;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int n_total  = 0;
    int n_passed = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_c(add_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf)
    );

    ripple_carry_adder4bit u_adder (
        .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .c(add_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set, check latency and outputs, leave the block in DONE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] e_res, input logic e_cout,
                          input logic e_ovf);
        int lat;
        op_a = a; op_b = b; op_cin = ci; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_a = 16'hDEAD; op_b = 16'hBEEF; op_cin = 1'b0;
        chk({tag, "_add_a0"}, 32'(add_a), 32'(a[3:0]));
        chk({tag, "_add_cin0"}, 32'(add_cin), 32'(ci));
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_result"}, 32'(result), 32'(e_res));
        chk({tag, "_cout"}, 32'(cout), 32'(e_cout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        chk({tag, "_add_a_done"}, 32'(add_a), 32'd0);
    endtask

    task automatic release_done(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;

        // 1: reset
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);

        // 2..4: basic adds
        run_op("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        release_done("add1234");
        run_op("addffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        release_done("addffff");
        run_op("add7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // 5: hold DONE with in_valid asserted
        op_a = 16'h1111; op_b = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_result", 32'(result), 32'h8000);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("hold_exit_out_valid", 32'(out_valid), 32'd0);
        chk("hold_exit_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("hold_no_reaccept", 32'(in_ready), 32'd1);
        chk("hold_result_kept", 32'(result), 32'h8000);

        // 6: reset mid-run, then a fresh op
        op_a = 16'hAAAA; op_b = 16'h5555; op_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        repeat (4) tick();
        chk("abort_stays_idle", 32'(out_valid), 32'd0);
        run_op("add0f0f", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);
        release_done("add0f0f");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
